// File: rtl/tdc_pulse_seq.sv
// Bus-programmable stimulus sequencer for the TDC: an optional timestamp-reset
// pulse followed by a train of SIGNAL pulses with programmable delay, width and gap.
module tdc_pulse_seq #(
  parameter logic [15:0] BASEADDR = 16'h0000,
  parameter logic [15:0] HIGHADDR = 16'h000F,
  parameter logic [7:0]  VERSION  = 8'd1
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic [15:0] BUS_ADD,
  input  logic [7:0]  BUS_DATA_IN,
  output logic [7:0]  BUS_DATA_OUT,
  input  logic        BUS_RD,
  input  logic        BUS_WR,
  output logic        TS_RESET,
  output logic        SIGNAL,
  output logic        BUSY,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TSR  = 3'd1,
    ST_DLY  = 3'd2,
    ST_PLS  = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Bus handshake: BUS_RD / BUS_WR are single-cycle strobes qualified by the
  // address decode; there is no back-pressure, every strobe is accepted on the
  // edge that samples it, and read data appears on BUS_DATA_OUT one cycle later.
  logic [16:0] off_ext;
  logic [15:0] off;
  logic        sel;
  logic        wr_sel;
  logic        rd_sel;
  logic        soft_rst;
  logic        start;

  assign off_ext  = {1'b0, BUS_ADD} - {1'b0, BASEADDR};
  assign off      = off_ext[15:0];
  assign sel      = !off_ext[16] && (off <= (HIGHADDR - BASEADDR));
  assign wr_sel   = BUS_WR && sel;
  assign rd_sel   = BUS_RD && sel;
  assign soft_rst = wr_sel && (off == 16'd0);
  assign start    = wr_sel && (off == 16'd1);

  logic [7:0]  ctrl;
  logic [7:0]  tsr_width;
  logic [15:0] delay_val;
  logic [15:0] width_val;
  logic [15:0] repeat_val;
  logic [15:0] gap_val;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      ctrl       <= '0;
      tsr_width  <= '0;
      delay_val  <= '0;
      width_val  <= '0;
      repeat_val <= '0;
      gap_val    <= '0;
    end else if (soft_rst) begin
      ctrl       <= '0;
      tsr_width  <= '0;
      delay_val  <= '0;
      width_val  <= '0;
      repeat_val <= '0;
      gap_val    <= '0;
    end else if (wr_sel) begin
      case (off)
        16'd2:  ctrl              <= BUS_DATA_IN;
        16'd3:  tsr_width         <= BUS_DATA_IN;
        16'd4:  delay_val[7:0]    <= BUS_DATA_IN;
        16'd5:  delay_val[15:8]   <= BUS_DATA_IN;
        16'd6:  width_val[7:0]    <= BUS_DATA_IN;
        16'd7:  width_val[15:8]   <= BUS_DATA_IN;
        16'd8:  repeat_val[7:0]   <= BUS_DATA_IN;
        16'd9:  repeat_val[15:8]  <= BUS_DATA_IN;
        16'd10: gap_val[7:0]      <= BUS_DATA_IN;
        16'd11: gap_val[15:8]     <= BUS_DATA_IN;
        default: ;
      endcase
    end
  end

  // Counter load for a phase of nominal length n: zero behaves as one cycle.
  function automatic logic [15:0] phase_load(input logic [15:0] n);
    return (n == 16'd0) ? 16'd0 : n - 16'd1;
  endfunction

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] pulse_cnt;
  logic [15:0] pulse_next;
  logic        done;
  logic        ts_reset_q;
  logic        signal_q;
  logic        busy_q;
  logic [15:0] sh_delay;
  logic [15:0] sh_width;
  logic [15:0] sh_repeat;
  logic [15:0] sh_gap;

  assign pulse_next = (pulse_cnt == 16'hFFFF) ? pulse_cnt : pulse_cnt + 16'd1;

  // TSR is the first phase, so its length is taken straight from the live
  // registers at START and needs no shadow copy.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pulse_cnt  <= '0;
      done       <= 1'b0;
      ts_reset_q <= 1'b0;
      signal_q   <= 1'b0;
      busy_q     <= 1'b0;
      sh_delay   <= '0;
      sh_width   <= '0;
      sh_repeat  <= '0;
      sh_gap     <= '0;
    end else if (soft_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pulse_cnt  <= '0;
      done       <= 1'b0;
      ts_reset_q <= 1'b0;
      signal_q   <= 1'b0;
      busy_q     <= 1'b0;
      sh_delay   <= '0;
      sh_width   <= '0;
      sh_repeat  <= '0;
      sh_gap     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sh_delay  <= delay_val;
            sh_width  <= width_val;
            sh_repeat <= repeat_val;
            sh_gap    <= gap_val;
            pulse_cnt <= '0;
            done      <= 1'b0;
            if (repeat_val == 16'd0) begin
              done <= 1'b1;
            end else if (ctrl[0]) begin
              state      <= ST_TSR;
              cnt        <= phase_load({8'd0, tsr_width});
              ts_reset_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state  <= ST_DLY;
              cnt    <= phase_load(delay_val);
              busy_q <= 1'b1;
            end
          end
        end
        ST_TSR: begin
          if (cnt == 16'd0) begin
            state      <= ST_DLY;
            cnt        <= phase_load(sh_delay);
            ts_reset_q <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_DLY: begin
          if (cnt == 16'd0) begin
            state    <= ST_PLS;
            cnt      <= phase_load(sh_width);
            signal_q <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_PLS: begin
          if (cnt == 16'd0) begin
            pulse_cnt <= pulse_next;
            signal_q  <= 1'b0;
            if (pulse_next == sh_repeat) begin
              state <= ST_DONE;
            end else begin
              state <= ST_GAP;
              cnt   <= phase_load(sh_gap);
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_GAP: begin
          if (cnt == 16'd0) begin
            state <= ST_DLY;
            cnt   <= phase_load(sh_delay);
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done   <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          ts_reset_q <= 1'b0;
          signal_q   <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'd0;
    case (off)
      16'd0:  rd_mux = VERSION;
      16'd1:  rd_mux = {6'b0, busy_q, done};
      16'd2:  rd_mux = ctrl;
      16'd3:  rd_mux = tsr_width;
      16'd4:  rd_mux = delay_val[7:0];
      16'd5:  rd_mux = delay_val[15:8];
      16'd6:  rd_mux = width_val[7:0];
      16'd7:  rd_mux = width_val[15:8];
      16'd8:  rd_mux = repeat_val[7:0];
      16'd9:  rd_mux = repeat_val[15:8];
      16'd10: rd_mux = gap_val[7:0];
      16'd11: rd_mux = gap_val[15:8];
      16'd12: rd_mux = pulse_cnt[7:0];
      16'd13: rd_mux = pulse_cnt[15:8];
      default: rd_mux = 8'd0;
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      BUS_DATA_OUT <= 8'd0;
    end else if (soft_rst) begin
      BUS_DATA_OUT <= 8'd0;
    end else if (rd_sel) begin
      BUS_DATA_OUT <= rd_mux;
    end
  end

  assign TS_RESET  = ts_reset_q;
  assign SIGNAL    = signal_q;
  assign BUSY      = busy_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_tdc_pulse_seq.sv
// Self-checking bench for tdc_pulse_seq: per-cycle output traces come from a
// phase-expansion model pushed into a queue before each START.
module tb_tdc_pulse_seq;

  logic        BUS_CLK;
  logic        BUS_RST;
  logic [15:0] BUS_ADD;
  logic [7:0]  BUS_DATA_IN;
  logic [7:0]  BUS_DATA_OUT;
  logic        BUS_RD;
  logic        BUS_WR;
  logic        TS_RESET;
  logic        SIGNAL;
  logic        BUSY;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Each entry is {BUSY, SIGNAL, TS_RESET} for one cycle.
  logic [2:0] exp_q[$];

  tdc_pulse_seq dut (
    .BUS_CLK      (BUS_CLK),
    .BUS_RST      (BUS_RST),
    .BUS_ADD      (BUS_ADD),
    .BUS_DATA_IN  (BUS_DATA_IN),
    .BUS_DATA_OUT (BUS_DATA_OUT),
    .BUS_RD       (BUS_RD),
    .BUS_WR       (BUS_WR),
    .TS_RESET     (TS_RESET),
    .SIGNAL       (SIGNAL),
    .BUSY         (BUSY),
    .dbg_state    (dbg_state)
  );

  // Clock and reset
  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: all are entered and left on a falling edge.
  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    BUS_ADD     = addr;
    BUS_DATA_IN = data;
    BUS_WR      = 1'b1;
    @(negedge BUS_CLK);
    BUS_WR      = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
    BUS_ADD = addr;
    BUS_RD  = 1'b1;
    @(negedge BUS_CLK);
    BUS_RD  = 1'b0;
    data    = BUS_DATA_OUT;
  endtask

  task automatic cfg(input logic tsr_en, input logic [7:0] tsrw, input logic [15:0] dly,
                     input logic [15:0] wid, input logic [15:0] rep, input logic [15:0] gp);
    bus_write(16'd2, {7'd0, tsr_en});
    bus_write(16'd3, tsrw);
    bus_write(16'd4, dly[7:0]);
    bus_write(16'd5, dly[15:8]);
    bus_write(16'd6, wid[7:0]);
    bus_write(16'd7, wid[15:8]);
    bus_write(16'd8, rep[7:0]);
    bus_write(16'd9, rep[15:8]);
    bus_write(16'd10, gp[7:0]);
    bus_write(16'd11, gp[15:8]);
  endtask

  function automatic int plen(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  // Reference model: expands a configuration into the cycle trace seen from t+1.
  task automatic push_trace(input logic tsr_en, input int tsrw, input int dly,
                            input int wid, input int rep, input int gp);
    if (tsr_en) repeat (plen(tsrw)) exp_q.push_back(3'b101);
    for (int p = 1; p <= rep; p++) begin
      repeat (plen(dly)) exp_q.push_back(3'b100);
      repeat (plen(wid)) exp_q.push_back(3'b110);
      if (p != rep) repeat (plen(gp)) exp_q.push_back(3'b100);
    end
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b000);
  endtask

  // Scoreboard: pops one expected entry per cycle; optionally injects a config
  // write and a second START part-way through the run.
  task automatic run_trace(input string name, input bit inject);
    int idx;
    logic [2:0] exp_v;
    logic [2:0] act_v;
    idx = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {BUSY, SIGNAL, TS_RESET};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: {busy,signal,ts_reset} got %b expected %b",
                 name, idx + 1, act_v, exp_v);
      end
      if (inject) begin
        if (idx == 3) begin
          BUS_ADD = 16'd6; BUS_DATA_IN = 8'd9; BUS_WR = 1'b1;
        end else if (idx == 4) begin
          BUS_ADD = 16'd1; BUS_DATA_IN = 8'd0; BUS_WR = 1'b1;
        end else if (idx == 5) begin
          BUS_WR = 1'b0;
        end
      end
      idx++;
      @(negedge BUS_CLK);
    end
  endtask

  task automatic check_read(input string name, input logic [15:0] addr, input logic [7:0] exp_v);
    logic [7:0] d;
    bus_read(addr, d);
    checks++;
    if (d !== exp_v) begin
      errors++;
      $display("FAIL %s: read 0x%04h got 0x%02h expected 0x%02h", name, addr, d, exp_v);
    end
  endtask

  task automatic test_reset();
    logic [2:0] o;
    BUS_RST = 1'b1;
    repeat (2) @(negedge BUS_CLK);
    checks++;
    if ({BUSY, SIGNAL, TS_RESET, BUS_DATA_OUT} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%h expected 000/00", {BUSY, SIGNAL, TS_RESET}, BUS_DATA_OUT);
    end
    BUS_RST = 1'b0;
    @(negedge BUS_CLK);
    check_read("version", 16'd0, 8'h01);
    check_read("status_after_reset", 16'd1, 8'h00);
    check_read("reserved_14", 16'd14, 8'h00);
    check_read("version_again", 16'd0, 8'h01);
    check_read("out_of_range_holds", 16'h0010, 8'h01);
    bus_write(16'd2, 8'hA5);
    check_read("ctrl_readback", 16'd2, 8'hA5);
    // Asynchronous reset mid-run
    cfg(1'b1, 8'd10, 16'd0, 16'd0, 16'd1, 16'd0);
    bus_write(16'd1, 8'd0);
    checks++;
    if ({BUSY, SIGNAL, TS_RESET} !== 3'b101) begin
      errors++;
      $display("FAIL tsr_running: got %b expected 101", {BUSY, SIGNAL, TS_RESET});
    end
    @(negedge BUS_CLK);
    #2 BUS_RST = 1'b1;
    #1 o = {BUSY, SIGNAL, TS_RESET};
    checks++;
    if (o !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_midrun: got %b expected 000", o);
    end
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    @(negedge BUS_CLK);
    check_read("version_after_async", 16'd0, 8'h01);
    check_read("status_after_async", 16'd1, 8'h00);
    check_read("ctrl_cleared", 16'd2, 8'h00);
  endtask

  task automatic test_basic();
    cfg(1'b1, 8'd1, 16'd3, 16'd2, 16'd2, 16'd4);
    push_trace(1'b1, 1, 3, 2, 2, 4);
    bus_write(16'd1, 8'd0);
    run_trace("basic", 1'b0);
    check_read("basic_status", 16'd1, 8'h01);
    check_read("basic_pulse_cnt_lo", 16'd12, 8'h02);
    check_read("basic_pulse_cnt_hi", 16'd13, 8'h00);
  endtask

  task automatic test_zero_fields();
    cfg(1'b0, 8'd0, 16'd0, 16'd0, 16'd3, 16'd0);
    push_trace(1'b0, 0, 0, 0, 3, 0);
    bus_write(16'd1, 8'd0);
    run_trace("zero_fields", 1'b0);
    check_read("zero_pulse_cnt", 16'd12, 8'h03);
  endtask

  task automatic test_repeat_zero();
    cfg(1'b1, 8'd2, 16'd1, 16'd1, 16'd0, 16'd1);
    bus_write(16'd1, 8'd0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({BUSY, SIGNAL, TS_RESET} !== 3'b000) begin
        errors++;
        $display("FAIL repeat_zero cycle %0d: got %b expected 000", i + 1, {BUSY, SIGNAL, TS_RESET});
      end
      @(negedge BUS_CLK);
    end
    check_read("repeat_zero_status", 16'd1, 8'h01);
    check_read("repeat_zero_pulse_cnt", 16'd12, 8'h00);
  endtask

  task automatic test_busy_protect();
    cfg(1'b0, 8'd0, 16'd3, 16'd2, 16'd2, 16'd4);
    push_trace(1'b0, 0, 3, 2, 2, 4);
    bus_write(16'd1, 8'd0);
    run_trace("busy_protect_run1", 1'b1);
    check_read("busy_protect_width_reg", 16'd6, 8'd9);
    check_read("busy_protect_status", 16'd1, 8'h01);
    push_trace(1'b0, 0, 3, 9, 2, 4);
    bus_write(16'd1, 8'd0);
    run_trace("busy_protect_run2", 1'b0);
  endtask

  task automatic test_soft_reset();
    int waited;
    cfg(1'b0, 8'd0, 16'd2, 16'd5, 16'd1, 16'd0);
    bus_write(16'd1, 8'd0);
    waited = 0;
    while (SIGNAL !== 1'b1 && waited < 50) begin
      @(negedge BUS_CLK);
      waited++;
    end
    checks++;
    if (SIGNAL !== 1'b1) begin
      errors++;
      $display("FAIL soft_reset_wait: SIGNAL got %b expected 1 within 50 cycles", SIGNAL);
    end
    bus_write(16'd0, 8'd0);
    checks++;
    if ({BUSY, SIGNAL, TS_RESET} !== 3'b000) begin
      errors++;
      $display("FAIL soft_reset_outputs: got %b expected 000", {BUSY, SIGNAL, TS_RESET});
    end
    check_read("soft_reset_delay", 16'd4, 8'h00);
    check_read("soft_reset_width", 16'd6, 8'h00);
    check_read("soft_reset_repeat", 16'd8, 8'h00);
    check_read("soft_reset_status", 16'd1, 8'h00);
  endtask

  initial begin
    BUS_RST     = 1'b1;
    BUS_ADD     = 16'd0;
    BUS_DATA_IN = 8'd0;
    BUS_RD      = 1'b0;
    BUS_WR      = 1'b0;
    @(negedge BUS_CLK);
    test_reset();
    test_basic();
    test_zero_fields();
    test_repeat_zero();
    test_busy_protect();
    test_soft_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
